dcache_dm: RTL
==============

Name: dcache_dm

Overview:
- Direct-mapped, write-back, write-allocate data cache. Sits between the pipelined datapath's data-memory request port and the memory controller.
- Datapath side: responder for dmemREN/dmemWEN/dmemaddr/dmemstore requests. Returns dhit and dmemload.
- Memory side: initiator of single-word dREN/dWEN transactions, completed when dwait drops.
- On halt: flushes dirty lines, writes the hit count to 0x3100, then asserts flushed.

Parameters:
- SETS, 16, number of one-word lines; power of two, ≥2.
- IDX_W, $clog2(SETS), index width.
- CNT_ADDR, 32'h3100, address the hit count is written to at end of flush.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  asynchronous active-low reset.
- halt  input  1  datapath halted; starts flush; level, sampled in IDLE.
- dmemREN  input  1  datapath read request.
- dmemWEN  input  1  datapath write request.
- dmemaddr  input  32  byte address; [1:0] ignored.
- dmemstore  input  32  write data.
- dhit  output  1  request serviced this cycle.
- dmemload  output  32  read data, valid when dhit.
- flushed  output  1  flush and count write complete.
- dREN  output  1  memory read request.
- dWEN  output  1  memory write request.
- daddr  output  32  memory word address, [1:0]=00.
- dstore  output  32  memory write data.
- dwait  input  1  memory busy; transaction completes in the cycle dwait=0 while the request is held.
- dload  input  32  memory read data, valid when dwait=0.

Behaviour:
- Address split: index = dmemaddr[IDX_W+1:2]; tag = dmemaddr[31:IDX_W+2].
- Per-line state: valid, dirty, tag, data.
- Reset (async, nRST=0):
  - All valid/dirty bits cleared; hit_count=0; flush index=0; state=IDLE; replay=0.
  - dhit, flushed, dREN, dWEN = 0; daddr, dstore, dmemload = 0.
  - Reset mid-transaction drops dREN/dWEN immediately.
- States: IDLE, WB, ALLOC, FLUSH, CNT, DONE.
- IDLE:
  - halt=1: go to FLUSH. Halt has priority over any pending request; no dhit.
  - Request (REN|WEN) with valid & tag match is a hit:
    - dhit=1 combinationally in the same cycle.
    - dmemload = line data.
    - Write hit: data := dmemstore and dirty := 1 at the clock edge.
    - REN and WEN together are treated as a write.
  - Miss, victim valid & dirty: go to WB. Otherwise go to ALLOC. dhit=0.
  - No request: hold state.
  - dmemload = selected line data whenever in IDLE; don't-care otherwise.
- Hit counting: hit_count (32-bit, wraps) increments on each dhit, except when replay=1. replay is set on ALLOC completion and cleared after the next IDLE cycle, so the post-fill hit is not counted.
- WB:
  - dWEN=1; daddr = {victim tag, index, 2'b00}; dstore = victim data.
  - On dwait=0: dirty := 0; go to ALLOC.
- ALLOC:
  - dREN=1; daddr = {dmemaddr[31:2], 2'b00}.
  - On dwait=0: line := {valid=1, dirty=0, tag, dload}; replay := 1; go to IDLE.
  - The request is then serviced as a hit on the following cycle.
  - Miss latency = memory latency + 1 cycle (clean) or + WB latency (dirty).
- dREN and dWEN are never both 1. Address and data are stable while dwait=1.
- FLUSH:
  - Walks index 0..SETS-1 in ascending order.
  - Line valid & dirty: dWEN=1 with its address and data; on dwait=0, clear dirty and advance.
  - Clean line: advance in one cycle, no memory access.
  - After index SETS-1 completes: go to CNT.
- CNT:
  - dWEN=1; daddr=CNT_ADDR; dstore=hit_count.
  - On dwait=0: go to DONE.
- DONE:
  - flushed=1; no further memory traffic or dhit until reset.
  - halt deasserting is ignored.
- Datapath requests outside IDLE are held by the requester and not acknowledged.

Test Plan:
- Reset, read 0x40; memory dwait=1 for 2 cycles, then dload=32'hDEADBEEF → dREN with daddr=0x40. Next cycle dhit=1, dmemload=DEADBEEF. dREN never overlaps dWEN.
- Write 0x40 ← 32'h12345678 after the fill → dhit same cycle, no dREN/dWEN. A subsequent read of 0x40 returns 12345678 with dhit.
- Read 0x80 (SETS=16, same index as 0x40, dirty) → dWEN daddr=0x40 dstore=12345678 first, then dREN daddr=0x80, then dhit.
- Fresh reset; write 0x40 (miss), read 0x40 (hit), write 0x44 (miss); assert halt →
  - dWEN 0x40 then 0x44 with their data.
  - Then dWEN daddr=0x3100 dstore=1.
  - Then flushed=1 and held; halt low does not clear it.
- Assert nRST=0 while in ALLOC with dwait=1 → dREN=0 immediately. After release, a read of the previously filled 0x40 misses (valid cleared).
- Assert halt simultaneous with a read request to a valid line → no dhit; FLUSH entered; clean lines advance one per cycle (SETS+1 cycles to CNT with no dirty lines).

Source files
------------

// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// On halt it writes back every dirty line, stores the hit count, then raises flushed.
module dcache_dm #(
  parameter int          SETS     = 16,
  parameter int          IDX_W    = $clog2(SETS),
  parameter logic [31:0] CNT_ADDR = 32'h3100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int TAG_W = 32 - IDX_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_ALLOC, S_FLUSH, S_CNT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic [SETS-1:0]    dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [TAG_W-1:0]   tag_d  [SETS];
  logic [31:0]        data_q [SETS];
  logic [31:0]        data_d [SETS];
  logic [31:0]        hit_cnt_q, hit_cnt_d;
  logic [IDX_W-1:0]   flush_idx_q, flush_idx_d;
  logic               replay_q, replay_d;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               req;
  logic               req_hit;
  logic               unused_addr_lsb;

  assign req_idx         = dmemaddr[IDX_W+1:2];
  assign req_tag         = dmemaddr[31:IDX_W+2];
  assign req             = dmemREN | dmemWEN;
  assign req_hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr_lsb = ^dmemaddr[1:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      tag_q       <= '{default: '0};
      data_q      <= '{default: '0};
      hit_cnt_q   <= '0;
      flush_idx_q <= '0;
      replay_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      hit_cnt_q   <= hit_cnt_d;
      flush_idx_q <= flush_idx_d;
      replay_q    <= replay_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    hit_cnt_d   = hit_cnt_q;
    flush_idx_d = flush_idx_q;
    replay_d    = replay_q;
    dhit        = 1'b0;
    dmemload    = '0;
    flushed     = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    daddr       = '0;
    dstore      = '0;

    unique case (state_q)
      S_IDLE: begin
        dmemload = data_q[req_idx];
        replay_d = 1'b0;
        if (halt) begin
          state_d = S_FLUSH;
        end else if (req) begin
          if (req_hit) begin
            dhit = 1'b1;
            // The hit that completes a fill was already paid for as a miss.
            if (!replay_q) hit_cnt_d = hit_cnt_q + 32'd1;
            if (dmemWEN) begin
              data_d[req_idx]  = dmemstore;
              dirty_d[req_idx] = 1'b1;
            end
          end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d = S_WB;
          end else begin
            state_d = S_ALLOC;
          end
        end
      end

      S_WB: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[req_idx], req_idx, 2'b00};
        dstore = data_q[req_idx];
        if (!dwait) begin
          dirty_d[req_idx] = 1'b0;
          state_d          = S_ALLOC;
        end
      end

      S_ALLOC: begin
        dREN  = 1'b1;
        daddr = {dmemaddr[31:2], 2'b00};
        if (!dwait) begin
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          tag_d[req_idx]   = req_tag;
          data_d[req_idx]  = dload;
          replay_d         = 1'b1;
          state_d          = S_IDLE;
        end
      end

      S_FLUSH: begin
        if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
          dWEN   = 1'b1;
          daddr  = {tag_q[flush_idx_q], flush_idx_q, 2'b00};
          dstore = data_q[flush_idx_q];
          if (!dwait) begin
            dirty_d[flush_idx_q] = 1'b0;
            flush_idx_d          = flush_idx_q + 1'b1;
            if (flush_idx_q == LAST_IDX) state_d = S_CNT;
          end
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
          if (flush_idx_q == LAST_IDX) state_d = S_CNT;
        end
      end

      S_CNT: begin
        dWEN   = 1'b1;
        daddr  = CNT_ADDR;
        dstore = hit_cnt_q;
        if (!dwait) state_d = S_DONE;
      end

      S_DONE: begin
        flushed = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
